// File: rtl/parallel_in_serial_out_word_serializer_pkg.sv
// Shared types and constants for the parallel-in / serial-out word serializer.
package serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  localparam bit DEFAULT_IDLE_LEVEL = 1'b0;

  // Bit-counter width; at least one bit so a degenerate width still elaborates.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/parallel_in_serial_out_word_serializer_word_holding_register.sv
// One-entry word buffer between the valid/ready source and the shifter.
module word_holding_register #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_valid,
  input  logic                  i_drain,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_full,
  output logic                  o_ready
);

  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_full;
  logic                  w_accept;

  // Ready looks only at the registered flag, so a same-edge drain never enables an accept.
  assign o_ready  = !r_full && !i_reset;
  assign w_accept = i_valid && o_ready;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_data <= '0;
      r_full <= 1'b0;
    end else if (w_accept) begin
      r_data <= i_data;
      r_full <= 1'b1;
    end else if (i_drain && r_full) begin
      r_full <= 1'b0;
    end
  end

  assign o_data = r_data;
  assign o_full = r_full;

endmodule

// File: rtl/parallel_in_serial_out_word_serializer.sv
// Streams buffered parallel words one bit per Shift_En_In strobe, with
// gapless back-to-back frames via the holding register.
module parallel_in_serial_out_word_serializer
  import serializer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter bit          MSB_FIRST  = 1'b0,
  parameter bit          IDLE_LEVEL = DEFAULT_IDLE_LEVEL
) (
  input  logic                  Clk_In,
  input  logic                  Reset_In,
  input  logic [DATA_WIDTH-1:0] Parallel_Data_In,
  input  logic                  Data_Valid_In,
  output logic                  Data_Ready_Out,
  input  logic                  Shift_En_In,
  output logic                  Serial_Data_Out,
  output logic                  Serial_Valid_Out,
  output logic                  Frame_Start_Out,
  output logic                  Frame_Done_Out,
  output logic                  Busy_Out
);

  localparam int unsigned         CNT_W    = cnt_width(DATA_WIDTH);
  localparam logic [CNT_W-1:0]    LAST_CNT = CNT_W'(DATA_WIDTH - 1);

  ser_state_t            r_state;
  logic [DATA_WIDTH-1:0] r_shifter;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic                  r_serial;
  logic                  r_start;
  logic                  r_done;

  ser_state_t            w_next_state;
  logic [DATA_WIDTH-1:0] w_next_shifter;
  logic [CNT_W-1:0]      w_next_bit_cnt;
  logic                  w_next_serial;
  logic                  w_next_start;
  logic                  w_next_done;

  logic [DATA_WIDTH-1:0] w_hold_data;
  logic                  w_hold_full;
  logic                  w_ready;
  logic                  w_last;
  logic                  w_load;

  word_holding_register #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_hold (
    .i_clk   (Clk_In),
    .i_reset (Reset_In),
    .i_data  (Parallel_Data_In),
    .i_valid (Data_Valid_In),
    .i_drain (w_load),
    .o_data  (w_hold_data),
    .o_full  (w_hold_full),
    .o_ready (w_ready)
  );

  always_ff @(posedge Clk_In) begin
    if (Reset_In) begin
      r_state   <= IDLE;
      r_shifter <= '0;
      r_bit_cnt <= '0;
      r_serial  <= IDLE_LEVEL;
      r_start   <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_shifter <= w_next_shifter;
      r_bit_cnt <= w_next_bit_cnt;
      r_serial  <= w_next_serial;
      r_start   <= w_next_start;
      r_done    <= w_next_done;
    end
  end

  always_comb begin
    w_next_state   = r_state;
    w_next_shifter = r_shifter;
    w_next_bit_cnt = r_bit_cnt;
    w_next_serial  = r_serial;
    w_next_start   = 1'b0;
    w_next_done    = 1'b0;

    w_last = (r_state == SHIFT) && Shift_En_In && (r_bit_cnt == LAST_CNT);
    w_load = w_hold_full && ((r_state == IDLE) || w_last);

    w_next_done = w_last;

    // A load on the last-bit edge replaces the retire-to-idle path, keeping frames contiguous.
    if (w_load) begin
      w_next_state   = SHIFT;
      w_next_shifter = w_hold_data;
      w_next_bit_cnt = '0;
      w_next_serial  = MSB_FIRST ? w_hold_data[DATA_WIDTH-1] : w_hold_data[0];
      w_next_start   = 1'b1;
    end else if ((r_state == SHIFT) && Shift_En_In) begin
      if (w_last) begin
        w_next_state  = IDLE;
        w_next_serial = IDLE_LEVEL;
      end else begin
        w_next_bit_cnt = r_bit_cnt + CNT_W'(1);
        if (MSB_FIRST) begin
          w_next_shifter = {r_shifter[DATA_WIDTH-2:0], 1'b0};
          w_next_serial  = r_shifter[DATA_WIDTH-2];
        end else begin
          w_next_shifter = {1'b0, r_shifter[DATA_WIDTH-1:1]};
          w_next_serial  = r_shifter[1];
        end
      end
    end
  end

  assign Data_Ready_Out   = w_ready;
  assign Serial_Data_Out  = r_serial;
  assign Serial_Valid_Out = (r_state == SHIFT);
  assign Frame_Start_Out  = r_start;
  assign Frame_Done_Out   = r_done;
  assign Busy_Out         = (r_state == SHIFT) || w_hold_full;

endmodule

// File: tb/tb_parallel_in_serial_out_word_serializer.sv
// Directed bench: per-cycle vector table plus multi-cycle frame sequences,
// with a negedge-sampling right-shift SISO model on the serial output.
module tb_parallel_in_serial_out_word_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] data = '0;
  logic        valid = 1'b0;
  logic        se = 1'b1;
  logic        Data_Ready_Out, Serial_Data_Out, Serial_Valid_Out;
  logic        Frame_Start_Out, Frame_Done_Out, Busy_Out;

  int checks = 0;
  int failures = 0;

  parallel_in_serial_out_word_serializer #(
    .DATA_WIDTH (32),
    .MSB_FIRST  (1'b0),
    .IDLE_LEVEL (1'b0)
  ) dut (
    .Clk_In           (clk),
    .Reset_In         (rst),
    .Parallel_Data_In (data),
    .Data_Valid_In    (valid),
    .Data_Ready_Out   (Data_Ready_Out),
    .Shift_En_In      (se),
    .Serial_Data_Out  (Serial_Data_Out),
    .Serial_Valid_Out (Serial_Valid_Out),
    .Frame_Start_Out  (Frame_Start_Out),
    .Frame_Done_Out   (Frame_Done_Out),
    .Busy_Out         (Busy_Out)
  );

  always #5 clk = ~clk;

  // Downstream SISO and frame monitors, sampled mid-cycle.
  logic [31:0] siso = '0;
  logic        q_bits[$];
  int valid_cyc = 0, run = 0, max_run = 0;
  int done_cnt = 0, start_cnt = 0, both_cnt = 0;

  always @(negedge clk) begin
    if (Serial_Valid_Out && se) begin
      siso = {Serial_Data_Out, siso[31:1]};
      q_bits.push_back(Serial_Data_Out);
    end
    if (Serial_Valid_Out) begin
      valid_cyc++;
      run++;
      if (run > max_run) max_run = run;
    end else begin
      run = 0;
    end
    if (Frame_Done_Out) done_cnt++;
    if (Frame_Start_Out) start_cnt++;
    if (Frame_Done_Out && Frame_Start_Out) both_cnt++;
  end

  typedef struct {
    logic        rst;
    logic        valid;
    logic [31:0] data;
    logic        se;
    logic [5:0]  exp;   // {ready, svalid, serial, start, done, busy}
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    q_bits.delete();
    siso = '0;
    valid_cyc = 0; run = 0; max_run = 0;
    done_cnt = 0; start_cnt = 0; both_cnt = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; valid = 1'b0; se = 1'b1;
    step();
    rst = 1'b0;
    #1;
  endtask

  function automatic logic [31:0] frame_word(input int k);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < 32; i++)
      if (32 * k + i < q_bits.size()) w[i] = q_bits[32 * k + i];
    return w;
  endfunction

  // Send one word from IDLE and wait for the shifter to go idle again.
  task automatic send_word(input logic [31:0] w);
    int n;
    valid = 1'b1; data = w; se = 1'b1;
    #1;
    step();
    valid = 1'b0;
    n = 0;
    while ((Busy_Out || n == 0) && n < 60) begin
      step();
      n++;
    end
    chk("send_idle_timeout", 32'(n < 60), 32'd1);
  endtask

  logic [31:0] words3[3];
  logic [31:0] wa, wb, wc, wbeef;
  int idx, n, cyc, done_at;
  logic acc;

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    // ----- per-cycle vector table -----
    vecs[0] = '{1'b1, 1'b0, 32'h0, 1'b1, 6'b000000};
    vecs[1] = '{1'b0, 1'b1, 32'h5, 1'b0, 6'b000001};
    vecs[2] = '{1'b0, 1'b0, 32'h0, 1'b0, 6'b111101};
    vecs[3] = '{1'b0, 1'b0, 32'h0, 1'b0, 6'b111001};
    vecs[4] = '{1'b0, 1'b0, 32'h0, 1'b1, 6'b110001};
    vecs[5] = '{1'b0, 1'b0, 32'h0, 1'b1, 6'b111001};
    vecs[6] = '{1'b0, 1'b0, 32'h0, 1'b0, 6'b111001};
    vecs[7] = '{1'b1, 1'b0, 32'h0, 1'b0, 6'b000000};
    vecs[8] = '{1'b0, 1'b0, 32'h0, 1'b1, 6'b100000};
    for (int i = 0; i < 9; i++) begin
      rst = vecs[i].rst; valid = vecs[i].valid; data = vecs[i].data; se = vecs[i].se;
      step();
      chk($sformatf("vec%0d", i),
          32'({Data_Ready_Out, Serial_Valid_Out, Serial_Data_Out,
               Frame_Start_Out, Frame_Done_Out, Busy_Out}),
          32'(vecs[i].exp));
    end

    // ----- reset with shift enable tied high -----
    rst = 1'b1; se = 1'b1; valid = 1'b0;
    step();
    chk("rst_ready_low", 32'(Data_Ready_Out), 32'd0);
    chk("rst_serial", 32'({Serial_Valid_Out, Serial_Data_Out}), 32'd0);
    rst = 1'b0;
    step();
    chk("rst_ready_after", 32'(Data_Ready_Out), 32'd1);

    // ----- single word into the SISO -----
    do_reset();
    clear_mon();
    valid = 1'b1; data = 32'hA5A5_0F0F; se = 1'b1;
    step();
    valid = 1'b0;
    chk("t2_not_yet", 32'(Serial_Valid_Out), 32'd0);
    step();
    chk("t2_first_bit", 32'({Serial_Valid_Out, Frame_Start_Out, Serial_Data_Out}), 32'b111);
    n = 0;
    while (Serial_Valid_Out && n < 40) begin
      step();
      n++;
    end
    chk("t2_frame_len", 32'(n), 32'd32);
    chk("t2_done_pulse", 32'(Frame_Done_Out), 32'd1);
    step();
    chk("t2_siso", siso, 32'hA5A5_0F0F);
    chk("t2_done_cnt", 32'(done_cnt), 32'd1);
    chk("t2_idle_level", 32'(Serial_Data_Out), 32'd0);

    // ----- back-to-back words with valid held high -----
    do_reset();
    clear_mon();
    words3[0] = 32'h0000_0001; words3[1] = 32'h8000_0000; words3[2] = 32'hFFFF_FFFF;
    idx = 0; valid = 1'b1; data = words3[0]; se = 1'b1;
    n = 0;
    while (!(idx == 3 && !Busy_Out) && n < 200) begin
      #1;
      acc = valid && Data_Ready_Out;
      step();
      n++;
      if (acc) idx++;
      valid = (idx < 3);
      data = words3[(idx < 3) ? idx : 0];
    end
    step();
    chk("t3_timeout", 32'(n < 200), 32'd1);
    chk("t3_contig", 32'(max_run), 32'd96);
    chk("t3_coincide", 32'(both_cnt), 32'd2);
    chk("t3_done_cnt", 32'(done_cnt), 32'd3);
    chk("t3_nbits", 32'(q_bits.size()), 32'd96);
    for (int k = 0; k < 3; k++)
      chk($sformatf("t3_word%0d", k), frame_word(k), words3[k]);

    // ----- 1-of-3 shift strobes -----
    do_reset();
    clear_mon();
    se = 1'b0; valid = 1'b1; data = 32'h1234_5678;
    step();
    valid = 1'b0;
    step();
    chk("t4_start", 32'(Frame_Start_Out), 32'd1);
    cyc = 0; done_at = 0;
    while (cyc < 120 && done_at == 0) begin
      se = (cyc % 3 == 2);
      #1;
      step();
      cyc++;
      if (Frame_Done_Out) done_at = cyc;
    end
    se = 1'b1;
    chk("t4_done_at", 32'(done_at), 32'd96);
    chk("t4_valid_cycles", 32'(valid_cyc), 32'd96);
    chk("t4_word", frame_word(0), 32'h1234_5678);
    chk("t4_nbits", 32'(q_bits.size()), 32'd32);

    // ----- hold full while a third word is offered -----
    do_reset();
    clear_mon();
    wa = 32'hCAFE_0001; wb = 32'h0BAD_F00D; wc = 32'h7777_1357;
    se = 1'b1; valid = 1'b1; data = wa;
    step();
    data = wb;
    step();
    chk("t5_no_accept_while_full", 32'(Busy_Out && Frame_Start_Out), 32'd1);
    step();
    data = wc;
    #1;
    chk("t5_ready_low", 32'(Data_Ready_Out), 32'd0);
    n = 0;
    while (!Data_Ready_Out && n < 60) begin
      step();
      n++;
    end
    chk("t5_blocked_cycles", 32'(n), 32'd31);
    chk("t5_boundary", 32'({Frame_Start_Out, Frame_Done_Out}), 32'b11);
    step();
    valid = 1'b0;
    n = 0;
    while (Busy_Out && n < 100) begin
      step();
      n++;
    end
    step();
    chk("t5_starts", 32'(start_cnt), 32'd3);
    chk("t5_dones", 32'(done_cnt), 32'd3);
    chk("t5_nbits", 32'(q_bits.size()), 32'd96);
    chk("t5_word_a", frame_word(0), wa);
    chk("t5_word_b", frame_word(1), wb);
    chk("t5_word_c", frame_word(2), wc);

    // ----- reset mid-frame -----
    do_reset();
    clear_mon();
    wbeef = 32'hDEAD_BEEF;
    se = 1'b1; valid = 1'b1; data = wbeef;
    step();
    valid = 1'b0;
    step();
    for (int i = 0; i < 17; i++) step();
    chk("t6_bit17", 32'(Serial_Data_Out), 32'(wbeef[17]));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_after_reset",
        32'({Serial_Valid_Out, Serial_Data_Out, Frame_Start_Out, Frame_Done_Out, Busy_Out}),
        32'd0);
    step(); step(); step();
    chk("t6_no_done", 32'(done_cnt), 32'd0);
    clear_mon();
    send_word(32'h0000_00C3);
    step();
    chk("t6_next_word", frame_word(0), 32'h0000_00C3);
    chk("t6_next_done", 32'(done_cnt), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
